// File: rtl/bark_pkg.sv
// ---------------------------------------------------------------------------
// bark_pkg
// Shared types for the multi-cycle RV32I controller: base opcodes, funct3
// encodings, ALU operation codes and the controller state encoding, plus two
// small decode helpers used by the FSM.
// ---------------------------------------------------------------------------
package bark_pkg;

    typedef enum logic [6:0] {
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111,
        OPC_BRANCH = 7'b1100011,
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011,
        OPC_OP_IMM = 7'b0010011,
        OPC_OP     = 7'b0110011
    } opcode_t;

    typedef enum logic [2:0] {
        F3_ADD_SUB = 3'd0,
        F3_SLL     = 3'd1,
        F3_SLT     = 3'd2,
        F3_SLTU    = 3'd3,
        F3_XOR     = 3'd4,
        F3_SRL_SRA = 3'd5,
        F3_OR      = 3'd6,
        F3_AND     = 3'd7
    } funct3_t;

    typedef enum logic [2:0] {
        BR_BEQ  = 3'd0,
        BR_BNE  = 3'd1,
        BR_BLT  = 3'd4,
        BR_BGE  = 3'd5,
        BR_BLTU = 3'd6,
        BR_BGEU = 3'd7
    } branch_f3_t;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLL    = 4'd2,
        ALU_SLT    = 4'd3,
        ALU_SLTU   = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_OR     = 4'd8,
        ALU_AND    = 4'd9,
        ALU_PASS_B = 4'd10
    } alu_op_t;

    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_BR_TGT = 3'd4,
        S_MEM    = 3'd5,
        S_WB     = 3'd6,
        S_TRAP   = 3'd7
    } ctrl_state_t;

    function automatic logic is_legal_opcode(input logic [6:0] op);
        case (op)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
            OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP: return 1'b1;
            default:                                 return 1'b0;
        endcase
    endfunction

    // Branch outcome from the compare result latched by the datapath during EXEC.
    // Reserved funct3 codes 010/011 never branch.
    function automatic logic branch_taken(input logic [2:0] f3,
                                          input logic       zero,
                                          input logic       lt);
        case (f3)
            BR_BEQ:           return zero;
            BR_BNE:           return !zero;
            BR_BLT, BR_BLTU:  return lt;
            BR_BGE, BR_BGEU:  return !lt;
            default:          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// ---------------------------------------------------------------------------
// alu_decoder
// Combinational mapping of instruction fields to the ALU operation used in
// EXEC.
//   opcode  in  7  IR[6:0]
//   funct3  in  3  IR[14:12]
//   funct7  in  7  IR[31:25]; only bit 5 is significant (SUB/SRA/SRAI)
//   alu_op  out    alu_op_t code
// ---------------------------------------------------------------------------
module alu_decoder
    import bark_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output alu_op_t    alu_op
);

    logic alt;
    logic unused_funct7;

    assign alt           = funct7[5];
    assign unused_funct7 = ^{funct7[6], funct7[4:0]};

    always_comb begin
        alu_op = ALU_ADD;
        case (opcode)
            OPC_OP, OPC_OP_IMM: begin
                case (funct3)
                    // Immediate forms have no subtract; funct7 there is imm bits.
                    F3_ADD_SUB: alu_op = (opcode == OPC_OP && alt) ? ALU_SUB : ALU_ADD;
                    F3_SLL:     alu_op = ALU_SLL;
                    F3_SLT:     alu_op = ALU_SLT;
                    F3_SLTU:    alu_op = ALU_SLTU;
                    F3_XOR:     alu_op = ALU_XOR;
                    F3_SRL_SRA: alu_op = alt ? ALU_SRA : ALU_SRL;
                    F3_OR:      alu_op = ALU_OR;
                    F3_AND:     alu_op = ALU_AND;
                    default:    alu_op = ALU_ADD;
                endcase
            end
            OPC_BRANCH: begin
                case (funct3[2:1])
                    2'b10:   alu_op = ALU_SLT;
                    2'b11:   alu_op = ALU_SLTU;
                    default: alu_op = ALU_SUB;
                endcase
            end
            OPC_LUI: alu_op = ALU_PASS_B;
            default: alu_op = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// ---------------------------------------------------------------------------
// multicycle_controller
// Multi-cycle RV32I control FSM driving a shared datapath:
// RESET-wait -> FETCH -> DECODE -> EXEC -> (BR_TGT | MEM) -> WB -> FETCH.
// Inputs: clock, reset (async active-low), opcode/funct3/funct7 from the IR,
//   alu_zero/alu_lt compare flags, mem_ready handshake.
// Outputs: ALU op and operand selects, memory request/write/address select,
//   IR/regfile/PC enables and muxes, sticky illegal_insn and mem_timeout.
// ---------------------------------------------------------------------------
module multicycle_controller
    import bark_pkg::*;
#(
    parameter int unsigned ALU_CTRL_W  = 4,
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned RESET_WAIT  = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [6:0]            opcode,
    input  logic [2:0]            funct3,
    input  logic [6:0]            funct7,
    input  logic                  alu_zero,
    input  logic                  alu_lt,
    input  logic                  mem_ready,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic                  alu_a_sel,
    output logic [1:0]            alu_b_sel,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic                  mem_addr_sel,
    output logic                  ir_we,
    output logic                  reg_we,
    output logic [1:0]            reg_data_sel,
    output logic                  pc_we,
    output logic [1:0]            pc_next_sel,
    output logic                  illegal_insn,
    output logic                  mem_timeout
);

    localparam logic [3:0]  RST_LAST = 4'(RESET_WAIT - 1);
    localparam logic [15:0] TMO_LAST = 16'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

    ctrl_state_t state_q, state_d;
    logic [3:0]  rst_cnt_q, rst_cnt_d;
    logic [15:0] tmo_cnt_q, tmo_cnt_d;
    logic        redirect_q, redirect_d;
    logic        illegal_q, illegal_d;
    logic        timeout_q, timeout_d;

    alu_op_t dec_op;
    alu_op_t alu_op;
    logic    wait_expired;

    alu_decoder u_alu_decoder (
        .opcode (opcode),
        .funct3 (funct3),
        .funct7 (funct7),
        .alu_op (dec_op)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_RESET;
            rst_cnt_q  <= '0;
            tmo_cnt_q  <= '0;
            redirect_q <= 1'b0;
            illegal_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rst_cnt_q  <= rst_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            redirect_q <= redirect_d;
            illegal_q  <= illegal_d;
            timeout_q  <= timeout_d;
        end
    end

    // The wait counter holds the number of cycles already spent without
    // mem_ready; this cycle is the last allowed one when it reaches TMO_LAST.
    assign wait_expired = (MEM_TIMEOUT != 0) && (tmo_cnt_q == TMO_LAST);

    always_comb begin
        state_d      = state_q;
        rst_cnt_d    = rst_cnt_q;
        tmo_cnt_d    = '0;
        redirect_d   = 1'b0;
        illegal_d    = illegal_q;
        timeout_d    = timeout_q;
        alu_op       = ALU_ADD;
        alu_a_sel    = 1'b0;
        alu_b_sel    = 2'd0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_we        = 1'b0;
        reg_we       = 1'b0;
        reg_data_sel = 2'd0;
        pc_we        = 1'b0;
        pc_next_sel  = 2'd0;

        case (state_q)
            S_RESET: begin
                if (rst_cnt_q == RST_LAST) begin
                    rst_cnt_d = '0;
                    state_d   = S_FETCH;
                end else begin
                    rst_cnt_d = rst_cnt_q + 4'd1;
                end
            end
            S_FETCH: begin
                mem_req = 1'b1;
                // First fetch cycle after a taken branch commits the target
                // computed in BR_TGT.
                if (redirect_q) begin
                    pc_we       = 1'b1;
                    pc_next_sel = 2'd1;
                end
                if (mem_ready) begin
                    ir_we   = 1'b1;
                    state_d = S_DECODE;
                end else if (wait_expired) begin
                    timeout_d = 1'b1;
                    state_d   = S_TRAP;
                end else if (MEM_TIMEOUT != 0) begin
                    tmo_cnt_d = tmo_cnt_q + 16'd1;
                end
            end
            S_DECODE: begin
                // Branch/JAL target pc+imm precomputed while decoding.
                alu_a_sel = 1'b1;
                alu_b_sel = 2'd1;
                if (!is_legal_opcode(opcode)) begin
                    illegal_d = 1'b1;
                    state_d   = S_TRAP;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_op = dec_op;
                case (opcode)
                    OPC_OP: state_d = S_WB;
                    OPC_OP_IMM, OPC_LUI, OPC_JALR: begin
                        alu_b_sel = 2'd1;
                        state_d   = S_WB;
                    end
                    OPC_AUIPC, OPC_JAL: begin
                        alu_a_sel = 1'b1;
                        alu_b_sel = 2'd1;
                        state_d   = S_WB;
                    end
                    OPC_LOAD, OPC_STORE: begin
                        alu_b_sel = 2'd1;
                        state_d   = S_MEM;
                    end
                    OPC_BRANCH: state_d = S_BR_TGT;
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = S_TRAP;
                    end
                endcase
            end
            S_BR_TGT: begin
                if (branch_taken(funct3, alu_zero, alu_lt)) begin
                    alu_a_sel  = 1'b1;
                    alu_b_sel  = 2'd1;
                    redirect_d = 1'b1;
                end else begin
                    pc_we = 1'b1;
                end
                state_d = S_FETCH;
            end
            S_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = (opcode == OPC_STORE);
                if (mem_ready) begin
                    if (opcode == OPC_STORE) begin
                        pc_we   = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (wait_expired) begin
                    timeout_d = 1'b1;
                    state_d   = S_TRAP;
                end else if (MEM_TIMEOUT != 0) begin
                    tmo_cnt_d = tmo_cnt_q + 16'd1;
                end
            end
            S_WB: begin
                reg_we = 1'b1;
                pc_we  = 1'b1;
                case (opcode)
                    OPC_LOAD: reg_data_sel = 2'd1;
                    OPC_JAL: begin
                        reg_data_sel = 2'd2;
                        pc_next_sel  = 2'd1;
                    end
                    OPC_JALR: begin
                        reg_data_sel = 2'd2;
                        pc_next_sel  = 2'd2;
                    end
                    default: ;
                endcase
                state_d = S_FETCH;
            end
            S_TRAP: ;
            default: state_d = S_TRAP;
        endcase
    end

    assign alu_control  = ALU_CTRL_W'(alu_op);
    assign illegal_insn = illegal_q;
    assign mem_timeout  = timeout_q;

endmodule
